// File: rtl/time_of_day_counter.sv
// Time-of-day counter: divides a tick timebase into seconds and keeps hh:mm:ss.
// Supports validated time loads and provides binary and BCD outputs.
module time_of_day_counter #(
    parameter int unsigned TICKS_PER_SEC = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_tick,
    input  logic       i_load,
    input  logic [4:0] i_load_hour,
    input  logic [5:0] i_load_min,
    input  logic [5:0] i_load_sec,
    output logic       o_load_ack,
    output logic       o_load_err,
    output logic [4:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic [7:0] o_hour_bcd,
    output logic [7:0] o_min_bcd,
    output logic [7:0] o_sec_bcd,
    output logic       o_sec_pulse,
    output logic       o_day_pulse
);

    localparam logic [15:0] LastTick = 16'(TICKS_PER_SEC - 1);

    logic [15:0] prescaler_q, prescaler_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic        load_ack_q, load_ack_d;
    logic        load_err_q, load_err_d;
    logic        sec_pulse_q, sec_pulse_d;
    logic        day_pulse_q, day_pulse_d;
    logic        load_valid;

    // Inputs are at most 63, so six subtract-by-ten steps always finish the split.
    function automatic logic [7:0] to_bcd(input logic [5:0] value);
        logic [3:0] tens;
        logic [5:0] rest;
        tens = 4'd0;
        rest = value;
        for (int i = 0; i < 6; i++) begin
            if (rest >= 6'd10) begin
                rest = rest - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rest[3:0]};
    endfunction

    assign load_valid = i_load && (i_load_hour <= 5'd23) && (i_load_min <= 6'd59)
                        && (i_load_sec <= 6'd59);

    always_comb begin
        prescaler_d = prescaler_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        load_ack_d  = 1'b0;
        load_err_d  = 1'b0;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        if (load_valid) begin
            // A valid load wins over any tick arriving on the same edge.
            prescaler_d = '0;
            hour_d      = i_load_hour;
            min_d       = i_load_min;
            sec_d       = i_load_sec;
            load_ack_d  = 1'b1;
        end else begin
            load_err_d = i_load;
            if (i_enable && i_tick) begin
                if (prescaler_q == LastTick) begin
                    prescaler_d = '0;
                    sec_pulse_d = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            if (hour_q == 5'd23) begin
                                hour_d      = '0;
                                day_pulse_d = 1'b1;
                            end else begin
                                hour_d = hour_q + 5'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    prescaler_d = prescaler_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prescaler_q <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            load_ack_q  <= 1'b0;
            load_err_q  <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            load_ack_q  <= load_ack_d;
            load_err_q  <= load_err_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    assign o_hour      = hour_q;
    assign o_min       = min_q;
    assign o_sec       = sec_q;
    assign o_hour_bcd  = to_bcd({1'b0, hour_q});
    assign o_min_bcd   = to_bcd(min_q);
    assign o_sec_bcd   = to_bcd(sec_q);
    assign o_load_ack  = load_ack_q;
    assign o_load_err  = load_err_q;
    assign o_sec_pulse = sec_pulse_q;
    assign o_day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with TICKS_PER_SEC=4.
// Inputs change at the falling edge; outputs are checked at the following falling edge.
module tb_time_of_day_counter;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_load = 1'b0;
    logic [4:0] i_load_hour = '0;
    logic [5:0] i_load_min = '0;
    logic [5:0] i_load_sec = '0;
    logic       o_load_ack, o_load_err, o_sec_pulse, o_day_pulse;
    logic [4:0] o_hour;
    logic [5:0] o_min, o_sec;
    logic [7:0] o_hour_bcd, o_min_bcd, o_sec_bcd;

    int errors = 0;
    int checks = 0;

    time_of_day_counter #(.TICKS_PER_SEC(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_tick      (i_tick),
        .i_load      (i_load),
        .i_load_hour (i_load_hour),
        .i_load_min  (i_load_min),
        .i_load_sec  (i_load_sec),
        .o_load_ack  (o_load_ack),
        .o_load_err  (o_load_err),
        .o_hour      (o_hour),
        .o_min       (o_min),
        .o_sec       (o_sec),
        .o_hour_bcd  (o_hour_bcd),
        .o_min_bcd   (o_min_bcd),
        .o_sec_bcd   (o_sec_bcd),
        .o_sec_pulse (o_sec_pulse),
        .o_day_pulse (o_day_pulse)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the rising edge take them, return at the next falling edge.
    task automatic cyc(input logic rst, input logic en, input logic tick, input logic ld,
                       input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        i_rst       = rst;
        i_enable    = en;
        i_tick      = tick;
        i_load      = ld;
        i_load_hour = h;
        i_load_min  = m;
        i_load_sec  = s;
        @(negedge i_clk);
    endtask

    task automatic tick1(input logic en);
        cyc(1'b0, en, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
    endtask

    task automatic chk_time(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s);
        chk({tag, "_hour"}, 32'(o_hour), 32'(h));
        chk({tag, "_min"}, 32'(o_min), 32'(m));
        chk({tag, "_sec"}, 32'(o_sec), 32'(s));
    endtask

    task automatic chk_flags(input string tag, input logic ack, input logic err,
                             input logic sp, input logic dp);
        chk({tag, "_ack"}, 32'(o_load_ack), 32'(ack));
        chk({tag, "_err"}, 32'(o_load_err), 32'(err));
        chk({tag, "_secp"}, 32'(o_sec_pulse), 32'(sp));
        chk({tag, "_dayp"}, 32'(o_day_pulse), 32'(dp));
    endtask

    initial begin
        @(negedge i_clk);
        // Reset with a load and tick present: both discarded.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 6'd4, 6'd5);
        chk_time("rst", 5'd0, 6'd0, 6'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_bcd", {8'h0, o_hour_bcd, o_min_bcd, o_sec_bcd}, 32'h0);

        // Basic counting: 8 ticks, pulse after ticks 4 and 8.
        for (int i = 1; i <= 8; i++) begin
            tick1(1'b1);
            chk($sformatf("cnt_secp%0d", i), 32'(o_sec_pulse), 32'((i % 4) == 0));
            idle();
            chk($sformatf("cnt_idle%0d", i), 32'(o_sec_pulse), 32'h0);
        end
        chk_time("cnt", 5'd0, 6'd0, 6'd2);
        chk("cnt_bcd", 32'(o_sec_bcd), 32'h02);

        // Minute-to-hour carry without a day rollover.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 6'd59, 6'd59);
        chk("carry_ack", 32'(o_load_ack), 32'h1);
        for (int i = 0; i < 4; i++) tick1(1'b1);
        chk_time("carry", 5'd2, 6'd0, 6'd0);
        chk_flags("carry", 1'b0, 1'b0, 1'b1, 1'b0);

        // Day rollover.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd23, 6'd59, 6'd59);
        chk_flags("day_ld", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("day_ld", 5'd23, 6'd59, 6'd59);
        chk("day_ld_bcd", {8'h0, o_hour_bcd, o_min_bcd, o_sec_bcd}, 32'h00235959);
        idle();
        chk("day_ack_once", 32'(o_load_ack), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick1(1'b1);
            chk($sformatf("day_pre%0d", i), {30'h0, o_sec_pulse, o_day_pulse}, 32'h0);
        end
        tick1(1'b1);
        chk_time("day", 5'd0, 6'd0, 6'd0);
        chk_flags("day", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("day_bcd", {8'h0, o_hour_bcd, o_min_bcd, o_sec_bcd}, 32'h0);
        idle();
        chk("day_after", {30'h0, o_sec_pulse, o_day_pulse}, 32'h0);

        // Invalid loads, held on consecutive cycles.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd24, 6'd0, 6'd0);
        chk_flags("bad_hr", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd12, 6'd60, 6'd0);
        chk_flags("bad_min", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_time("bad", 5'd0, 6'd0, 6'd0);
        idle();
        chk("bad_err_clr", 32'(o_load_err), 32'h0);

        // Load colliding with the fourth tick: tick dropped, prescaler cleared.
        for (int i = 0; i < 3; i++) tick1(1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 6'd20, 6'd30);
        chk_flags("coll", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("coll", 5'd10, 6'd20, 6'd30);
        for (int i = 0; i < 3; i++) tick1(1'b1);
        chk("coll_hold", 32'(o_sec), 32'd30);
        tick1(1'b1);
        chk("coll_sec", 32'(o_sec), 32'd31);
        chk("coll_secp", 32'(o_sec_pulse), 32'h1);

        // Enable gating: ticks while disabled are ignored, prescaler kept.
        tick1(1'b1);
        tick1(1'b1);
        for (int i = 0; i < 5; i++) tick1(1'b0);
        chk("gate_hold", 32'(o_sec), 32'd31);
        tick1(1'b1);
        chk("gate_pre3", {o_sec_pulse, 25'h0, o_sec}, 32'd31);
        tick1(1'b1);
        chk("gate_sec", {o_sec_pulse, 25'h0, o_sec}, {1'b1, 31'd32});

        // Load accepted while disabled, then reset mid-operation with prescaler=3.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 6'd6, 6'd7);
        chk("dis_ack", 32'(o_load_ack), 32'h1);
        for (int i = 0; i < 3; i++) tick1(1'b1);
        chk_time("pre_rst", 5'd5, 6'd6, 6'd7);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 6'd9, 6'd9);
        chk_time("mid_rst", 5'd0, 6'd0, 6'd0);
        chk_flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_bcd", {8'h0, o_hour_bcd, o_min_bcd, o_sec_bcd}, 32'h0);

        // Counting restarts from prescaler 0.
        for (int i = 0; i < 3; i++) tick1(1'b1);
        chk("post_rst_hold", {o_sec_pulse, 25'h0, o_sec}, 32'd0);
        tick1(1'b1);
        chk("post_rst_sec", {o_sec_pulse, 25'h0, o_sec}, {1'b1, 31'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 1000, meaning i_tick pulses per second; legal range 2..65535.
REQ-002 SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 SHALL have port i_enable, input, 1 bit, run enable; high means count ticks, low means hold time.
REQ-005 SHALL have port i_tick, input, 1 bit, single-cycle timebase pulse from the upstream 32-bit counter.
REQ-006 SHALL have port i_load, input, 1 bit, time-set request, sampled every cycle.
REQ-007 SHALL have ports i_load_hour (5 bits), i_load_min (6 bits) and i_load_sec (6 bits), all inputs, binary set values sampled when i_load=1.
REQ-008 SHALL have port o_load_ack, output, 1 bit, one-cycle pulse confirming a load was accepted.
REQ-009 SHALL have port o_load_err, output, 1 bit, one-cycle pulse flagging a load that was rejected.
REQ-010 SHALL have ports o_hour (5 bits), o_min (6 bits) and o_sec (6 bits), all outputs, binary time of day.
REQ-011 SHALL have ports o_hour_bcd, o_min_bcd and o_sec_bcd, outputs, 8 bits each, two-digit BCD with tens digit in [7:4].
REQ-012 SHALL have port o_sec_pulse, output, 1 bit, one-cycle pulse on each seconds increment.
REQ-013 SHALL have port o_day_pulse, output, 1 bit, one-cycle pulse on the 23:59:59 to 00:00:00 rollover.

Function
REQ-014 SHALL hold a 16-bit prescaler counting i_tick pulses only in cycles where i_enable=1.
REQ-015 SHALL advance time when i_enable=1, i_tick=1 and prescaler=TICKS_PER_SEC-1:
- prescaler wraps to 0;
- seconds increment in that same edge.
REQ-016 SHALL hold the prescaler and the time when i_enable=0; the prescaler is not cleared. i_tick is ignored while disabled.
REQ-017 SHALL apply the rollover chain in a single edge:
- sec 59 goes to 0 and increments min;
- min 59 goes to 0 and increments hour;
- hour 23 goes to 0.
REQ-018 SHALL register o_sec_pulse high for exactly the one cycle following each seconds increment, aligned with the new o_sec value.
REQ-019 SHALL register o_day_pulse high only in the cycle in which o_sec_pulse reports the transition to 00:00:00.
REQ-020 SHALL validate a load when i_load=1; it is valid only if hour≤23, min≤59 and sec≤59.
REQ-021 SHALL, for a valid load:
- write the time on that edge;
- clear the prescaler to 0;
- pulse o_load_ack in the next cycle;
- suppress o_sec_pulse and o_day_pulse for that edge.
REQ-022 SHALL, for an invalid load, leave time and prescaler unchanged and pulse o_load_err in the next cycle; normal tick counting continues that cycle.
REQ-023 SHALL give a valid load priority over a simultaneous advancing tick; that tick is dropped.
REQ-024 SHALL accept a load regardless of i_enable.
REQ-025 SHALL accept a held i_load=1 every cycle; each cycle produces its own ack or err pulse.
REQ-026 SHALL derive the BCD outputs combinationally from the registered binary values; zero latency versus the binary outputs.
REQ-027 SHALL keep the binary time registers within legal ranges at all times.

Reset
REQ-028 SHALL, on the edge where i_rst=1:
- zero the prescaler, o_hour, o_min and o_sec;
- drive all BCD outputs to 8'h00;
- clear o_load_ack, o_load_err, o_sec_pulse and o_day_pulse.
REQ-029 SHALL give i_rst priority over i_load and i_tick; a load or tick in the reset cycle is discarded and produces no ack or err.
REQ-030 SHALL, after i_rst deasserts, count from prescaler 0 on the first qualified tick.

Verification (TICKS_PER_SEC=4)
REQ-031 SHALL cover basic counting:
- stimulus: after reset, i_enable=1, 8 i_tick pulses;
- required: o_sec=2; o_sec_pulse exactly twice, one cycle after ticks 4 and 8; o_sec_bcd=8'h02.
REQ-032 SHALL cover day rollover:
- stimulus: load 23:59:59, then 4 ticks;
- required: o_load_ack one cycle after the load; time reaches 00:00:00; o_day_pulse and o_sec_pulse coincide once; BCD outputs all 8'h00.
REQ-033 SHALL cover an invalid load:
- stimulus: load 24:00:00, then load 12:60:00;
- required: o_load_err pulses twice; time unchanged; no o_load_ack.
REQ-034 SHALL cover load and tick collision:
- stimulus: 3 ticks, then i_load of 10:20:30 in the same cycle as tick 4;
- required: time is 10:20:30; no o_sec_pulse; a further 4 ticks are needed to reach 10:20:31.
REQ-035 SHALL cover enable gating:
- stimulus: 2 ticks, i_enable=0 with 5 ticks, then i_enable=1 with 2 ticks;
- required: exactly one seconds increment, occurring on the final tick.
REQ-036 SHALL cover reset mid-operation:
- stimulus: running at 05:06:07 with prescaler=3, assert i_rst together with i_load and i_tick;
- required: the next cycle shows all outputs zero, no ack, err or sec pulse.
